// File: rtl/tc_9_residue_encoder_pkg.sv
// ============================================================================
// Module : tc9_defs (package)
// Brief  : Shared constants, FSM encoding and binary-to-thermometer helper
//          for the mod-9 RNS channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tc9_defs;

  localparam int TC9_MOD = 9;
  localparam int TC9_W   = 8;
  localparam int RES_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tc9_state_t;

  // Thermometer bit k is set iff k <= r, so r=0 gives all zeros and r=8 all ones.
  function automatic logic [TC9_W:1] bin_to_tc(input logic [RES_W-1:0] r);
    logic [TC9_W:1] tc;
    tc = '0;
    for (int k = 1; k <= TC9_W; k++) begin
      tc[k] = (r >= RES_W'(k));
    end
    return tc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tc_9_bin_to_tc.sv
// ============================================================================
// Module : tc_9_bin_to_tc
// Brief  : Combinational 4-bit residue to [8:1] thermometer-code converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tc_9_bin_to_tc
  import tc9_defs::*;
(
  input  logic [RES_W-1:0] r,
  output logic [TC9_W:1]   tc
);

  for (genvar k = 1; k <= TC9_W; k++) begin : g_tc
    assign tc[k] = (r >= RES_W'(k));
  end

endmodule

`default_nettype wire

// File: rtl/tc_9_residue_encoder.sv
// ============================================================================
// Module : tc_9_residue_encoder
// Brief  : Serial MSB-first binary to mod-9 residue converter with TC-9 and
//          binary residue outputs and a valid/ready handshake on both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tc_9_residue_encoder
  import tc9_defs::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TC9_W:1]    res_tc,
  output logic [RES_W-1:0]  res_bin
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tc9_state_t          r_state;
  logic [DATA_W-1:0]   r_shreg;
  logic [RES_W-1:0]    r_res;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [TC9_W:1]      r_res_tc;
  logic [RES_W-1:0]    r_res_bin;

  logic [4:0]          w_t;
  logic [4:0]          w_t_sub;
  logic [RES_W-1:0]    w_r_next;
  logic [TC9_W:1]      w_tc_next;
  logic                w_last;

  // t = 2r + b never exceeds 17, so a single conditional subtract keeps r in 0..8.
  assign w_t      = {r_res, 1'b0} + {4'd0, r_shreg[DATA_W-1]};
  assign w_t_sub  = w_t - 5'(TC9_MOD);
  assign w_r_next = (w_t >= 5'(TC9_MOD)) ? w_t_sub[RES_W-1:0] : w_t[RES_W-1:0];
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  tc_9_bin_to_tc u_bin_to_tc (
    .r  (w_r_next),
    .tc (w_tc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_res_tc    <= '0;
      r_res_bin   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_shreg    <= in_data;
            r_res      <= '0;
            r_cnt      <= '0;
          end
        end
        RUN: begin
          r_res   <= w_r_next;
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_res_tc    <= w_tc_next;
            r_res_bin   <= w_r_next;
          end
        end
        DONE: begin
          // Result registers stay untouched here so backpressure holds them stable.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res_tc    = r_res_tc;
  assign res_bin   = r_res_bin;

endmodule

`default_nettype wire

// File: tb/tb_tc_9_residue_encoder.sv
// ============================================================================
// Module : tb_tc_9_residue_encoder
// Brief  : Directed and swept checks of the mod-9 residue encoder (DATA_W=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tc_9_residue_encoder;
  import tc9_defs::*;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [8:1]        res_tc;
  logic [3:0]        res_bin;

  int n_checks = 0;
  int n_pass   = 0;

  tc_9_residue_encoder #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_tc    (res_tc),
    .res_bin   (res_bin)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_tc(input int r);
    logic [8:0] one;
    one = 9'd1 << r;
    return 8'(one - 9'd1);
  endfunction

  // Waits for in_ready, hands in d, then checks latency and residue outputs.
  task automatic run_word(input logic [DATA_W-1:0] d, input int exp_bin,
                          input logic [7:0] exp_t, input string tag);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, DATA_W);
    check({tag, "_bin"}, res_bin, exp_bin);
    check({tag, "_tc"},  res_tc,  exp_t);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain_ov"}, out_valid, 1'b0);
    check({tag, "_drain_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ov",  out_valid, 1'b0);
    check("rst_rdy", in_ready,  1'b0);
    check("rst_tc",  res_tc,    8'h00);
    check("rst_bin", res_bin,   4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", in_ready, 1'b1);

    // Directed vectors, residues hand-computed.
    run_word(16'd0,    0, 8'h00, "zero");   drain("zero");
    run_word(16'd17,   8, 8'hFF, "d17");    drain("d17");
    run_word(16'd9,    0, 8'h00, "d9");     drain("d9");
    run_word(16'hFFFF, 6, 8'h3F, "ffff");   drain("ffff");
    run_word(16'd1234, 1, 8'h01, "d1234");  drain("d1234");
    run_word(16'd5,    5, 8'h1F, "d5");     drain("d5");

    // Backpressure with in_valid asserted: must be ignored while DONE.
    out_ready = 1'b0;
    run_word(16'd100, 1, 8'h01, "bp");
    in_valid = 1'b1;
    in_data  = 16'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ov",  out_valid, 1'b1);
      check("bp_rdy", in_ready,  1'b0);
      check("bp_bin", res_bin,   4'd1);
      check("bp_tc",  res_tc,    8'h01);
    end
    in_valid = 1'b0;
    drain("bp");

    // Back-to-back: in_valid held high, handshakes must be DATA_W+2 apart.
    begin
      logic [DATA_W-1:0] words[4];
      int exp_q[$];
      int hs_cyc[$];
      int cyc, idx, nres;
      logic adv;
      words[0] = 16'd17; words[1] = 16'd1234; words[2] = 16'hFFFF; words[3] = 16'd8;
      idx = 0; cyc = 0; nres = 0; adv = 1'b0;
      in_valid = 1'b1;
      in_data  = words[0];
      while (nres < 4 && cyc < 200) begin
        if (out_valid && exp_q.size() > 0) begin
          check("b2b_bin", res_bin, exp_q[0]);
          check("b2b_tc",  res_tc,  exp_tc(exp_q[0]));
          void'(exp_q.pop_front());
          nres++;
        end
        if (adv) begin
          adv = 1'b0;
          if (idx < 4) in_data = words[idx];
          else in_valid = 1'b0;
        end
        if (in_ready && in_valid) begin
          exp_q.push_back(int'(in_data % 9));
          hs_cyc.push_back(cyc);
          idx++;
          adv = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      check("b2b_nres", nres, 4);
      check("b2b_nhs", hs_cyc.size(), 4);
      for (int i = 1; i < hs_cyc.size(); i++)
        check("b2b_gap", hs_cyc[i] - hs_cyc[i-1], DATA_W + 2);
    end

    // Reset at RUN cycle 7 after a nonzero result is sitting on the outputs.
    run_word(16'd17, 8, 8'hFF, "pre_rst");
    drain("pre_rst");
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd1234;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 7; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_ov",  out_valid, 1'b0);
    check("mrst_tc",  res_tc,    8'h00);
    check("mrst_bin", res_bin,   4'd0);
    check("mrst_rdy", in_ready,  1'b0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("mrst_stale", seen, 0);
      check("mrst_idle_rdy", in_ready, 1'b1);
    end

    // Random sweep against x % 9.
    for (int n = 0; n < 1000; n++) begin
      logic [DATA_W-1:0] x;
      int r;
      x = DATA_W'($urandom);
      r = int'(x % 9);
      run_word(x, r, exp_tc(r), "rnd");
      check("rnd_legal", res_tc, bin_to_tc(res_bin));
      out_ready = 1'b1;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
